// File: rtl/oled_cmd_queue.sv
// rtl/oled_cmd_queue.sv - debounced button command queue feeding the OLED driver (option: OLED_CMDQ_AUTOCOL_EN)
module oled_cmd_queue #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btnU,
  input  logic                          btnL,
  input  logic                          btnR,
  input  logic [15:0]                   sw,
  input  logic                          drv_ready,
  output logic                          showchar,
  output logic                          showbmp,
  output logic                          clear,
  output logic [7:0]                    charval,
  output logic [1:0]                    char_row,
  output logic [3:0]                    char_col,
  output logic [1:0]                    bmp,
  output logic                          idle,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0]   C_FULL = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [1:0] OP_CHAR  = 2'b01;
  localparam logic [1:0] OP_BMP   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // button bit order: [2]=clear (btnR), [1]=bitmap (btnL), [0]=char (btnU)
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [2:0]    r_db_q;
  logic [CW-1:0] r_cnt [3];

  logic [2:0]    w_rise;
  logic          w_req;
  logic          w_multi;
  logic [1:0]    w_op;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // entry layout: {opcode[1:0], sw[15:0]}
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_level;
  logic [17:0]   w_head;

  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [7:0]    r_charval;
  logic [1:0]    r_char_row;
  logic [3:0]    r_char_col;
  logic [1:0]    r_bmp;
  logic          r_overflow;

`ifdef OLED_CMDQ_AUTOCOL_EN
  // {row[1:0], col[3:0]}; a plain 6-bit increment gives col wrap into row and row wrap to 0
  logic [5:0]    r_cursor;
`endif

  assign w_raw = {btnR, btnL, btnU};

  // Synchronise raw buttons, then accept a new level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == C_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Request arbitration: clear beats bitmap beats char; a pop this cycle frees a full slot.
  always_comb begin
    w_rise  = r_db & ~r_db_q;
    w_req   = |w_rise;
    w_multi = (w_rise[2] & w_rise[1]) | (w_rise[2] & w_rise[0]) | (w_rise[1] & w_rise[0]);
    w_op    = w_rise[2] ? OP_CLEAR : (w_rise[1] ? OP_BMP : OP_CHAR);
    w_full  = (r_level == C_FULL);
    w_pop   = (r_state == S_IDLE) && (r_level != '0) && drv_ready;
    w_push  = w_req && (!w_full || w_pop);
    w_drop  = w_multi || (w_req && w_full && !w_pop);
    w_head  = r_mem[r_rptr];
  end

  // Command FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_op, sw};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky record of any dropped request.
  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Issue FSM; operands are loaded only on the pop and held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_charval  <= '0;
      r_char_row <= '0;
      r_char_col <= '0;
      r_bmp      <= '0;
`ifdef OLED_CMDQ_AUTOCOL_EN
      r_cursor   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op      <= w_head[17:16];
            r_charval <= w_head[7:0];
            r_bmp     <= w_head[15:14];
`ifdef OLED_CMDQ_AUTOCOL_EN
            if (w_head[17:16] == OP_CHAR) begin
              r_char_row <= r_cursor[5:4];
              r_char_col <= r_cursor[3:0];
              r_cursor   <= r_cursor + 1'b1;
            end else begin
              r_char_row <= w_head[9:8];
              r_char_col <= w_head[13:10];
              if (w_head[17:16] == OP_CLEAR) r_cursor <= '0;
            end
`else
            r_char_row <= w_head[9:8];
            r_char_col <= w_head[13:10];
`endif
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE:     r_state <= S_WAIT_ACK;
        S_WAIT_ACK:  if (!drv_ready) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (drv_ready)  r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign showchar = (r_state == S_ISSUE) && (r_op == OP_CHAR);
  assign showbmp  = (r_state == S_ISSUE) && (r_op == OP_BMP);
  assign clear    = (r_state == S_ISSUE) && (r_op == OP_CLEAR);
  assign charval  = r_charval;
  assign char_row = r_char_row;
  assign char_col = r_char_col;
  assign bmp      = r_bmp;
  assign overflow = r_overflow;
  assign level    = r_level;
  assign idle     = (r_state == S_IDLE) && (r_level == '0) && drv_ready;

endmodule

// File: doc/oled_cmd_queue.md
# oled_cmd_queue

Parametrised front end for the OLED driver. Debounces the three command buttons, captures a snapshot of the switch operands on each press, and queues the resulting commands in a small FIFO. Commands are issued to the driver one at a time, only when it reports ready, so presses made while the panel is busy are not lost. The block sits between board I/O and the `oledDriver` instance in the top level.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a button level is accepted (≥2).
- `FIFO_DEPTH`, 4: command queue entries; power of two, 2..16.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, synchronous, active-high.
- `btnU  in  1`: show-character request (asynchronous raw input).
- `btnL  in  1`: show-bitmap request (asynchronous raw input).
- `btnR  in  1`: clear request (asynchronous raw input).
- `sw  in  16`: operand switches: [7:0] char value, [9:8] row, [13:10] col, [15:14] bitmap.
- `drv_ready  in  1`: driver idle/ready.
- `showchar  out  1`: one-cycle command pulse to the driver.
- `showbmp  out  1`: one-cycle command pulse to the driver.
- `clear  out  1`: one-cycle command pulse to the driver.
- `charval  out  8`: operand of the command in flight; held stable from pulse until the command completes.
- `char_row  out  2`: operand of the command in flight; held stable from pulse until the command completes.
- `char_col  out  4`: operand of the command in flight; held stable from pulse until the command completes.
- `bmp  out  2`: operand of the command in flight; held stable from pulse until the command completes.
- `idle  out  1`: high when FSM is IDLE, FIFO is empty, and `drv_ready` is high.
- `overflow  out  1`: sticky; a request was dropped.
- `level  out  $clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- **Input path:** each button passes a 2-flop synchroniser, then a per-button debouncer.
  - Counter restarts on any change of the synchronised level.
  - Debounced level updates when the counter reaches `DEBOUNCE_CYCLES`.
- **Edge detection:** rising edge of a debounced level is a request. Falling edges are ignored.
- **Enqueue:** one entry per request, 18 bits: opcode[1:0] (01 char, 10 bmp, 11 clear) plus `sw` operands sampled in the edge cycle.
- **Simultaneous edges:** priority is clear > bmp > char. Only the winner is enqueued; the losers set `overflow`.
- **FIFO full:** the request is dropped, `overflow` is set, and FIFO contents are unchanged.
- **FSM states:**
  - IDLE: if FIFO is non-empty and `drv_ready` is high, pop the head, load operand registers, and go to ISSUE.
  - ISSUE: assert the opcode's pulse for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for `drv_ready` low, then go to WAIT_DONE.
  - WAIT_DONE: wait for `drv_ready` high, then go to IDLE.
- **Push and pop together:** a push and a pop in the same cycle are both honoured, including when the FIFO is full (pop frees a slot first). `level` is unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`. `level` counts 0..`FIFO_DEPTH`.
- **Reset:**
  - All registers cleared, FSM to IDLE, FIFO flushed.
  - All outputs 0: pulses, operands, `overflow`, `level`.
  - `idle` follows its definition.
  - Reset in any state aborts the command. A pulse never straddles reset.

## Timing
- **Button to debounced level:** exactly 2 + `DEBOUNCE_CYCLES` cycles from a stable raw level, plus ≤1 cycle of synchroniser uncertainty.
- **Edge to enqueue:** entry is written on the clock after the debounced rise; `level` increments that cycle.
- **Dequeue to pulse:** with FIFO non-empty, IDLE, and `drv_ready` high, the pulse is asserted 1 cycle after the pop (ISSUE is registered).
- **Back-to-back commands:** minimum 4 cycles between consecutive pulses (ISSUE, WAIT_ACK, WAIT_DONE, IDLE), assuming the driver drops and raises `drv_ready` within 1 cycle each.
- **Operand stability:** operands change only on the pop cycle.

## Configuration
- `OLED_CMDQ_AUTOCOL_EN`
  - **Defined:** char commands use an internal cursor instead of `sw[13:8]`.
    - Cursor resets to row 0, col 0.
    - Each issued char advances col; col 15→0 increments row; row 3→0 wraps.
    - A clear command resets the cursor to 0,0.
  - **Undefined:** row and col are always taken from the enqueued snapshot. No cursor logic is present.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.
- **Reset:** `rst` high 3 cycles with buttons high → all pulses 0, `level`=0, `overflow`=0, and no command after release until a new rising edge.
- **Bounce:** `btnU` toggles every 2 cycles for 20 cycles, then holds high, with `sw`=16'h2541 → exactly one `showchar` pulse: `charval`=8'h41, `char_row`=1, `char_col`=9.
- **Queueing:** `drv_ready` held low while `btnL` is pressed 3 times → `level`=3, no pulse. Raise `drv_ready` with a model dropping it 1 cycle after each pulse → 3 `showbmp` pulses, each ≥4 cycles apart, `level` returns to 0.
- **Overflow:** 5 presses while `drv_ready`=0 → `level`=4, `overflow`=1 and sticky; 4 commands are issued after ready.
- **Priority:** `btnR` and `btnU` rise in the same cycle → one `clear` is issued, `overflow`=1.
- **Reset mid-command:** reset asserted in WAIT_DONE with 2 entries queued → no further pulses, `level`=0. With `OLED_CMDQ_AUTOCOL_EN`: 17 char presses → col sequence 0..15, 0, with row 0→1.
